data_mem_responder: RTL

//  Memory-side responder for the core's data port: accepts load/store requests from the

---
 rtl/data_mem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-port memory responder: single outstanding request, word RAM, fixed wait-state delay.
// Optional access-error checking is enabled by defining DMEM_ERR_EN.
module data_mem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;

    logic        op_we, op_err, enter_resp;
    logic [31:0] op_addr, op_wdata, offset;
    logic [DEPTH_LOG2-1:0] index;

    logic [31:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_N == 4'd0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == WAIT_N) state_next = S_RESP;
                else               cnt_next   = cnt + 4'd1;
            end
            S_RESP: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, so use the live inputs.
    assign op_we      = (state == S_IDLE) ? req_we    : we_q;
    assign op_addr    = (state == S_IDLE) ? req_addr  : addr_q;
    assign op_wdata   = (state == S_IDLE) ? req_wdata : wdata_q;
    assign offset     = op_addr - BASE_ADDR;
    assign index      = offset[DEPTH_LOG2+1:2];
    assign enter_resp = (state_next == S_RESP) && !reset;

`ifdef DMEM_ERR_EN
    assign op_err = (op_addr[1:0] != 2'b00) || (op_addr < BASE_ADDR)
                  || (offset[31:DEPTH_LOG2+2] != '0);
    logic unused_bits;
    assign unused_bits = ^offset[1:0];
`else
    assign op_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{offset[1:0], offset[31:DEPTH_LOG2+2]};
`endif

    // NOTE: the RAM array has no reset so it can map onto block memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) ram[index] <= op_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= op_err;
            rsp_rdata <= (op_we || op_err) ? 32'd0 : ram[index];
        end
    end

endmodule
